// File: rtl/tnaf_scheduler_pkg.sv
// Shared constants, encodings and types for the TNAF scalar-multiply scheduler
// and its digit FIFO.
package tnaf_scheduler_pkg;

  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_AW        = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W        = FIFO_AW + 1;
  localparam int SUSPEND_THRESH = 6;
  localparam int DCOUNT_W       = 9;

  typedef enum logic [1:0] {
    CMD_FROB  = 2'b00,
    CMD_ADD   = 2'b01,
    CMD_SUB   = 2'b10,
    CMD_FINAL = 2'b11
  } pu_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_ISSUE_OP   = 3'd2,
    ST_ISSUE_FROB = 3'd3,
    ST_FINAL      = 3'd4,
    ST_FINISH     = 3'd5
  } state_e;

  // One tau-adic NAF digit: value is 0 when nz=0, otherwise -1 or +1 by sign.
  typedef struct packed {
    logic nz;
    logic sign;
  } digit_t;

  function automatic pu_cmd_e op_cmd(input digit_t d);
    return d.sign ? CMD_SUB : CMD_ADD;
  endfunction

endpackage

// File: rtl/tnaf_scheduler_if.sv
// Converter and point-unit handshake bundle; master is the scheduler side.
interface tnaf_scheduler_if;

  logic       sc_start;
  logic       sc_tbit_ready;
  logic       sc_tbit_nz;
  logic       sc_tbit_sign;
  logic       sc_done;
  logic       sc_suspend;
  logic [1:0] pu_cmd;
  logic       pu_cmd_valid;
  logic       pu_cmd_ready;

  modport master (
    output sc_start,
    output sc_suspend,
    output pu_cmd,
    output pu_cmd_valid,
    input  sc_tbit_ready,
    input  sc_tbit_nz,
    input  sc_tbit_sign,
    input  sc_done,
    input  pu_cmd_ready
  );

  modport slave (
    input  sc_start,
    input  sc_suspend,
    input  pu_cmd,
    input  pu_cmd_valid,
    output sc_tbit_ready,
    output sc_tbit_nz,
    output sc_tbit_sign,
    output sc_done,
    output pu_cmd_ready
  );

endinterface

// File: rtl/tnaf_digit_fifo.sv
// 8-entry digit FIFO with registered storage; head is the oldest entry and a
// write at a full level is dropped unless a pop happens in the same cycle.
module tnaf_digit_fifo
  import tnaf_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  digit_t             wr_data,
  input  logic               rd_en,
  output digit_t             head,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               full;
  logic               empty;
  logic               do_wr;
  logic               do_rd;
  digit_t             mem [FIFO_DEPTH];

  always_comb begin
    full     = (level_q == LEVEL_W'(FIFO_DEPTH));
    empty    = (level_q == '0);
    do_rd    = rd_en && !empty && !flush;
    // At full, a same-cycle pop frees the slot the write lands in.
    do_wr    = wr_en && !flush && (!full || do_rd);
    overflow = wr_en && !flush && full && !do_rd;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  assign head  = mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/tnaf_scheduler.sv
// Scheduler for a tau-adic NAF scalar multiply: buffers converter digits and
// sequences FROB/ADD/SUB/FINAL commands to the point unit.
module tnaf_scheduler
  import tnaf_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  tnaf_scheduler_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DCOUNT_W-1:0] digit_count,
  output logic [LEVEL_W-1:0]  fifo_level
);

  state_e              state_q, state_d;
  logic [DCOUNT_W-1:0] digit_count_q, digit_count_d;
  logic                error_q, error_d;
  logic                sc_suspend_q, sc_suspend_d;

  logic                fifo_wr;
  logic                fifo_rd;
  logic                fifo_flush;
  logic                fifo_ovf;
  digit_t              fifo_wdata;
  digit_t              fifo_head;
  logic [LEVEL_W-1:0]  fifo_lvl;

  logic                sc_start_c;
  logic                done_c;
  logic                cmd_valid_c;
  pu_cmd_e             cmd_c;

  assign busy       = (state_q != ST_IDLE);
  assign fifo_wr    = bus.sc_tbit_ready && busy;
  assign fifo_wdata = digit_t'({bus.sc_tbit_nz, bus.sc_tbit_sign});

  tnaf_digit_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wdata),
    .rd_en    (fifo_rd),
    .head     (fifo_head),
    .level    (fifo_lvl),
    .overflow (fifo_ovf)
  );

  // Suspend lags the level by one cycle; the threshold leaves room for the
  // digits the converter already has in flight when it sees it.
  assign sc_suspend_d = (fifo_lvl >= LEVEL_W'(SUSPEND_THRESH));

  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    error_d       = error_q | fifo_ovf;
    sc_start_c    = 1'b0;
    done_c        = 1'b0;
    cmd_valid_c   = 1'b0;
    cmd_c         = CMD_FROB;
    fifo_rd       = 1'b0;
    fifo_flush    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fifo_flush = 1'b1;
        if (start) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        sc_start_c    = 1'b1;
        fifo_flush    = 1'b1;
        digit_count_d = '0;
        error_d       = 1'b0;
        state_d       = ST_ISSUE_OP;
      end
      ST_ISSUE_OP: begin
        if (fifo_lvl != '0) begin
          if (fifo_head.nz) begin
            cmd_valid_c = 1'b1;
            cmd_c       = op_cmd(fifo_head);
            if (bus.pu_cmd_ready) state_d = ST_ISSUE_FROB;
          end else begin
            state_d = ST_ISSUE_FROB;
          end
        end else if (bus.sc_done) begin
          state_d = ST_FINAL;
        end
      end
      ST_ISSUE_FROB: begin
        cmd_valid_c = 1'b1;
        cmd_c       = CMD_FROB;
        if (bus.pu_cmd_ready) begin
          fifo_rd = 1'b1;
          if (digit_count_q != '1) digit_count_d = digit_count_q + 1'b1;
          state_d = ST_ISSUE_OP;
        end
      end
      ST_FINAL: begin
        cmd_valid_c = 1'b1;
        cmd_c       = CMD_FINAL;
        if (bus.pu_cmd_ready) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      digit_count_q <= '0;
      error_q       <= 1'b0;
      sc_suspend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      error_q       <= error_d;
      sc_suspend_q  <= sc_suspend_d;
    end
  end

  assign bus.sc_start     = sc_start_c;
  assign bus.sc_suspend   = sc_suspend_q;
  assign bus.pu_cmd       = cmd_c;
  assign bus.pu_cmd_valid = cmd_valid_c;
  assign done             = done_c;
  assign error            = error_q;
  assign digit_count      = digit_count_q;
  assign fifo_level       = fifo_lvl;

endmodule

// File: tb/tb_tnaf_scheduler.sv
// Bench for tnaf_scheduler: digit-queue reference model checked every cycle,
// directed corner scenarios and randomized multiplications.
module tb_tnaf_scheduler;
  import tnaf_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] digit_count;
  logic [3:0] fifo_level;

  tnaf_scheduler_if bus ();

  tnaf_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .digit_count (digit_count),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the digits held, whether the head's add/sub has gone out,
  // and the run-level flags, advanced once per cycle from observed inputs.
  logic [1:0] m_q[$];
  logic [1:0] cmd_log[$];
  bit         m_busy, m_launch, m_op_done, m_final_acc, m_err, m_susp;
  bit         m_launch_n, m_final_n;
  int         m_cnt;
  int         m_done_cnt = 0;
  bit         prev_stall;
  logic [1:0] prev_cmd;
  logic [1:0] exp_cmd;
  bit         acc, pop, wr;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_valid", int'(bus.pu_cmd_valid), 0);
      chk("rst_cmd", int'(bus.pu_cmd), 0);
      chk("rst_sc_start", int'(bus.sc_start), 0);
      chk("rst_suspend", int'(bus.sc_suspend), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_count", int'(digit_count), 0);
      m_q.delete();
      m_busy = 0; m_launch = 0; m_op_done = 0; m_final_acc = 0;
      m_err = 0; m_susp = 0; m_cnt = 0; prev_stall = 0;
    end else begin
      if (done) m_done_cnt++;
      chk("busy", int'(busy), int'(m_busy));
      chk("sc_start", int'(bus.sc_start), int'(m_launch));
      chk("done", int'(done), int'(m_final_acc));
      chk("error", int'(error), int'(m_err));
      chk("fifo_level", int'(fifo_level), m_q.size());
      chk("digit_count", int'(digit_count), m_cnt);
      chk("sc_suspend", int'(bus.sc_suspend), int'(m_susp));

      exp_cmd = CMD_FINAL;
      if (m_q.size() > 0)
        exp_cmd = (m_q[0][1] && !m_op_done) ? (m_q[0][0] ? CMD_SUB : CMD_ADD) : CMD_FROB;
      if (bus.pu_cmd_valid) begin
        chk("valid_state", int'(m_busy && !m_launch && !m_final_acc), 1);
        chk("pu_cmd", int'(bus.pu_cmd), int'(exp_cmd));
      end
      if (prev_stall) begin
        chk("hold_valid", int'(bus.pu_cmd_valid), 1);
        chk("hold_cmd", int'(bus.pu_cmd), int'(prev_cmd));
      end
      prev_stall = bus.pu_cmd_valid && !bus.pu_cmd_ready;
      prev_cmd   = bus.pu_cmd;

      acc = bus.pu_cmd_valid && bus.pu_cmd_ready;
      pop = acc && (exp_cmd == CMD_FROB) && (m_q.size() > 0);
      wr  = bus.sc_tbit_ready && m_busy && !m_launch;
      if (acc) cmd_log.push_back(bus.pu_cmd);

      m_susp     = (m_q.size() >= 6);
      m_launch_n = !m_busy && start;
      m_final_n  = acc && (exp_cmd == CMD_FINAL);

      if (m_launch) begin
        m_q.delete(); m_cnt = 0; m_err = 0; m_op_done = 0;
      end else if (!m_busy) begin
        m_q.delete();
      end else begin
        if (pop) begin
          void'(m_q.pop_front());
          m_op_done = 0;
          if (m_cnt < 511) m_cnt++;
        end else if (acc && (exp_cmd == CMD_ADD || exp_cmd == CMD_SUB)) begin
          m_op_done = 1;
        end
        if (wr) begin
          if (m_q.size() < 8) m_q.push_back({bus.sc_tbit_nz, bus.sc_tbit_sign});
          else m_err = 1;
        end
      end

      if (m_final_acc) m_busy = 0;
      else if (m_launch_n) m_busy = 1;
      m_launch    = m_launch_n;
      m_final_acc = m_final_n;
    end
  end

  task automatic push(input logic nz, input logic sign);
    bus.sc_tbit_ready = 1'b1;
    bus.sc_tbit_nz    = nz;
    bus.sc_tbit_sign  = sign;
    tick();
    bus.sc_tbit_ready = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = m_done_cnt;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_done_cnt != d0) break;
    end
    chk(name, int'(m_done_cnt != d0), 1);
  endtask

  task automatic run_txn(input int n, input bit zeros, input int rdy_pct);
    int sent, nzs, d0;
    bit fin;
    logic nz;
    sent = 0; nzs = 0; fin = 0;
    d0 = m_done_cnt;
    bus.sc_done = 1'b0;
    cmd_log.delete();
    launch();
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      bus.pu_cmd_ready  = (int'($urandom_range(99)) < rdy_pct);
      bus.sc_tbit_ready = 1'b0;
      if (sent == n) begin
        bus.sc_done = 1'b1;
      end else if (!bus.sc_suspend && $urandom_range(3) != 0) begin
        nz = zeros ? 1'b0 : 1'($urandom_range(1));
        bus.sc_tbit_ready = 1'b1;
        bus.sc_tbit_nz    = nz;
        bus.sc_tbit_sign  = 1'($urandom_range(1));
        nzs += int'(nz);
        sent++;
      end
      tick();
      fin = (m_done_cnt != d0);
    end
    bus.sc_tbit_ready = 1'b0;
    bus.sc_done       = 1'b0;
    bus.pu_cmd_ready  = 1'b0;
    chk("txn_done", int'(fin), 1);
    chk("txn_count", int'(digit_count), (n > 511) ? 511 : n);
    chk("txn_cmds", cmd_log.size(), n + nzs + 1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_seq[6];
    int         d0;

    rst = 1'b0;
    start = 1'b0;
    bus.sc_tbit_ready = 1'b0;
    bus.sc_tbit_nz    = 1'b0;
    bus.sc_tbit_sign  = 1'b0;
    bus.sc_done       = 1'b0;
    bus.pu_cmd_ready  = 1'b0;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_level", int'(fifo_level), 0);
    rst = 1'b1;
    tick();

    // Three digits +1, 0, -1 with the point unit always ready.
    bus.pu_cmd_ready = 1'b1;
    cmd_log.delete();
    d0 = m_done_cnt;
    launch();
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    push(1'b1, 1'b1);
    bus.sc_done = 1'b1;
    wait_done("a_done", 50);
    bus.sc_done = 1'b0;
    repeat (3) tick();
    exp_seq = '{CMD_ADD, CMD_FROB, CMD_FROB, CMD_SUB, CMD_FROB, CMD_FINAL};
    chk("a_ncmds", cmd_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < cmd_log.size()) chk("a_cmd_seq", int'(cmd_log[i]), int'(exp_seq[i]));
    chk("a_count", int'(digit_count), 3);
    chk("a_done_pulses", m_done_cnt - d0, 1);

    // Fill the FIFO with the point unit stalled.
    bus.pu_cmd_ready = 1'b0;
    launch();
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        chk("b_level6", int'(fifo_level), 6);
        chk("b_susp_at6", int'(bus.sc_suspend), 0);
      end
      if (i == 7) begin
        chk("b_level7", int'(fifo_level), 7);
        chk("b_susp_after6", int'(bus.sc_suspend), 1);
      end
      push(1'b1, 1'(i % 2));
    end
    chk("b_level8", int'(fifo_level), 8);
    chk("b_susp8", int'(bus.sc_suspend), 1);
    chk("b_err0", int'(error), 0);

    // Push and pop together at level 8.
    bus.pu_cmd_ready = 1'b1;
    tick();
    push(1'b0, 1'b0);
    bus.pu_cmd_ready = 1'b0;
    chk("c_level8", int'(fifo_level), 8);
    chk("c_err0", int'(error), 0);

    // Ninth digit with nothing leaving: dropped, error sticks.
    push(1'b1, 1'b0);
    chk("d_level8", int'(fifo_level), 8);
    chk("d_err1", int'(error), 1);
    repeat (3) tick();
    chk("d_err_held", int'(error), 1);
    bus.pu_cmd_ready = 1'b1;
    bus.sc_done = 1'b1;
    wait_done("d_done", 100);
    bus.sc_done = 1'b0;
    bus.pu_cmd_ready = 1'b0;
    tick();
    chk("d_count", int'(digit_count), 9);
    chk("d_err_after_done", int'(error), 1);
    rst = 1'b0;
    tick();
    chk("d_err_cleared", int'(error), 0);
    rst = 1'b1;
    tick();

    // Reset while waiting on a FROB with five digits held.
    launch();
    for (int i = 0; i < 5; i++) push(1'b1, 1'b0);
    bus.pu_cmd_ready = 1'b1;
    tick();
    bus.pu_cmd_ready = 1'b0;
    chk("e_level5", int'(fifo_level), 5);
    chk("e_frob_valid", int'(bus.pu_cmd_valid), 1);
    chk("e_frob_cmd", int'(bus.pu_cmd), int'(CMD_FROB));
    d0 = m_done_cnt;
    rst = 1'b0;
    #1;
    chk("e_busy0", int'(busy), 0);
    chk("e_valid0", int'(bus.pu_cmd_valid), 0);
    chk("e_level0", int'(fifo_level), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("e_no_done", m_done_cnt - d0, 0);
    chk("e_idle", int'(busy), 0);

    // Converter finishes with no digits at all.
    bus.pu_cmd_ready = 1'b1;
    bus.sc_done = 1'b1;
    cmd_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("f_done", 20);
    bus.sc_done = 1'b0;
    bus.pu_cmd_ready = 1'b0;
    chk("f_ncmds", cmd_log.size(), 1);
    if (cmd_log.size() > 0) chk("f_final", int'(cmd_log[0]), int'(CMD_FINAL));
    chk("f_count", int'(digit_count), 0);
    tick();

    for (int t = 0; t < 6; t++)
      run_txn(int'($urandom_range(1, 40)), 1'b0, int'($urandom_range(30, 100)));
    run_txn(515, 1'b1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
